// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch bank controller.
//   state_t : controller FSM states (ST_CHECK exists only with SR_READBACK_EN)
//   OP_SET / OP_CLR : command encodings carried on reqN_op
// Optional feature macro: SR_READBACK_EN.
package sr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
`ifdef SR_READBACK_EN
    , ST_CHECK
`endif
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_latch_bank_ctrl_if.sv
// Command interface between two requesters and the SR latch bank controller.
//   reqN_valid : requester N has a command
//   reqN_op    : 1 = set latch, 0 = clear latch
//   reqN_idx   : target latch index
//   reqN_ready : command accepted this cycle (combinational from the controller)
// Modports: master (requester side), slave (controller side).
interface sr_latch_bank_ctrl_if #(
  parameter int N_LATCH = 8
);
  localparam int IDX_W = $clog2(N_LATCH);

  logic             req0_valid;
  logic             req0_op;
  logic [IDX_W-1:0] req0_idx;
  logic             req0_ready;
  logic             req1_valid;
  logic             req1_op;
  logic [IDX_W-1:0] req1_idx;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_op, req0_idx, req1_valid, req1_op, req1_idx,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_idx, req1_valid, req1_op, req1_idx,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/sr_rr_arb.sv
// Two-requester round-robin arbiter with a 1-bit priority pointer.
//   clk, rst : clock, asynchronous active-high reset
//   en       : arbitration allowed (controller idle)
//   valid0/1 : requests
//   ready0/1 : acceptance, at most one high, combinational
//   grant    : index of the winning requester
// A lone request always wins; on a tie the pointer side wins. After every
// acceptance the pointer moves to the other side, so a held request waits at
// most one command slot.
module sr_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1,
  output logic grant
);
  logic ptr_q;
  logic accept;

  assign grant  = (valid0 && valid1) ? ptr_q : valid1;
  assign ready0 = en && valid0 && !grant;
  assign ready1 = en && valid1 && grant;
  assign accept = ready0 || ready1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= !grant;
    end
  end
endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Controller for a bank of N_LATCH external gated SR latches.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : two-requester command interface (slave modport)
//   latch_en  : per-latch enable, one-hot during PULSE, zero otherwise
//   latch_s/r : shared S and R lines, driven for the whole command
//   latch_q   : latch outputs, read back only with SR_READBACK_EN
//   busy      : high whenever the FSM is not IDLE
//   done      : one-cycle pulse in the final cycle of a command
//   err       : sticky readback mismatch flag (0 without SR_READBACK_EN)
// Command sequence: IDLE (accept) -> SETUP -> PULSE x PULSE_CYC -> HOLD
// [-> CHECK]. SETUP and HOLD are guard cycles so the enable only moves while
// S/R are stable. Optional feature macro: SR_READBACK_EN.
module sr_latch_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_LATCH   = 8,
  parameter int PULSE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_bank_ctrl_if.slave req,
  output logic [N_LATCH-1:0] latch_en,
  output logic               latch_s,
  output logic               latch_r,
  input  logic [N_LATCH-1:0] latch_q,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int IDX_W = $clog2(N_LATCH);
  localparam int CNT_W = $clog2(PULSE_CYC + 1);

  state_t           state_q, state_d;
  logic             op_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             idle;
  logic             grant;
  logic             accept;

  assign idle   = (state_q == ST_IDLE);
  assign accept = req.req0_ready || req.req1_ready;

  sr_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (idle),
    .valid0 (req.req0_valid),
    .valid1 (req.req1_valid),
    .ready0 (req.req0_ready),
    .ready1 (req.req1_ready),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture and pulse down-counter. The counter is loaded in SETUP so
  // PULSE lasts exactly PULSE_CYC cycles, leaving on the cycle it reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_CLR;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= grant ? req.req1_op  : req.req0_op;
        idx_q <= grant ? req.req1_idx : req.req0_idx;
      end
      if (state_q == ST_SETUP) begin
        cnt_q <= CNT_W'(PULSE_CYC - 1);
      end else if (state_q == ST_PULSE && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_PULSE;
      ST_PULSE: if (cnt_q == '0) state_d = ST_HOLD;
`ifdef SR_READBACK_EN
      ST_HOLD:  state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
`else
      ST_HOLD:  state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    latch_en = '0;
    if (state_q == ST_PULSE) latch_en[idx_q] = 1'b1;
  end

  assign busy    = !idle;
  assign latch_s = busy && (op_q == OP_SET);
  assign latch_r = busy && (op_q == OP_CLR);

`ifdef SR_READBACK_EN
  logic err_q;

  assign done = (state_q == ST_CHECK);
  assign err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == ST_CHECK && latch_q[idx_q] != op_q) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_latch_q;

  assign done           = (state_q == ST_HOLD);
  assign err            = 1'b0;
  assign unused_latch_q = ^latch_q;
`endif
endmodule
